// File: rtl/cpu54_pkg.sv
// Shared definitions for the 54-instruction pipeline's HI/LO machinery:
// the SPECIAL opcode, the HI/LO func codes, the instruction class and
// the multiply/divide sequencer state encoding.
package cpu54_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;

  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_MUL,
    CLS_DIV,
    CLS_MFHI,
    CLS_MFLO,
    CLS_MTHI,
    CLS_MTLO
  } hilo_cls_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_WAIT,
    ST_DIV_WAIT
  } seq_state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Bus between the HI/LO sequencer and the multiply/divide units.
// master: sequencer (drives operands, start pulses, signed flags).
// slave : units (return product, divider completion, quotient, remainder).
interface muldiv_sequencer_if;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mul_start;
  logic        mul_signed;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic        div_done;
  logic [31:0] div_quot;
  logic [31:0] div_rem;

  modport master (
    output op_a, op_b, mul_start, mul_signed, div_start, div_signed,
    input  mul_result, div_done, div_quot, div_rem
  );

  modport slave (
    input  op_a, op_b, mul_start, mul_signed, div_start, div_signed,
    output mul_result, div_done, div_quot, div_rem
  );
endinterface

// File: rtl/muldiv_sequencer_decode.sv
// Combinational classifier for HI/LO instructions in the ID stage.
// Ports: id_valid/id_op/id_func in; cls (hilo_cls_e) and is_signed out.
// An invalid ID slot always classifies as CLS_NONE.
module muldiv_decode
  import cpu54_pkg::*;
(
  input  logic      id_valid,
  input  logic [5:0] id_op,
  input  logic [5:0] id_func,
  output hilo_cls_e cls,
  output logic      is_signed
);

  always_comb begin
    cls       = CLS_NONE;
    is_signed = 1'b0;
    if (id_valid && (id_op == OP_SPECIAL)) begin
      case (id_func)
        FUNC_MULT:  begin cls = CLS_MUL; is_signed = 1'b1; end
        FUNC_MULTU: begin cls = CLS_MUL; end
        FUNC_DIV:   begin cls = CLS_DIV; is_signed = 1'b1; end
        FUNC_DIVU:  begin cls = CLS_DIV; end
        FUNC_MFHI:  cls = CLS_MFHI;
        FUNC_MFLO:  cls = CLS_MFLO;
        FUNC_MTHI:  cls = CLS_MTHI;
        FUNC_MTLO:  cls = CLS_MTLO;
        default:    cls = CLS_NONE;
      endcase
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multiply/divide sequencer: issues MULT(U)/DIV(U) to the units, owns HI/LO.
// Ports: clk, rst_n (sync, active-low); ID inputs id_valid/id_op/id_func/
// rs_val/rt_val; stall (comb); unit bus (master); div_by_zero; hi_out/lo_out.
module muldiv_sequencer
  import cpu54_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [5:0]          id_op,
  input  logic [5:0]          id_func,
  input  logic [31:0]         rs_val,
  input  logic [31:0]         rt_val,
  output logic                stall,
  muldiv_sequencer_if.master  unit,
  output logic                div_by_zero,
  output logic [31:0]         hi_out,
  output logic [31:0]         lo_out
);

  hilo_cls_e  cls;
  logic       is_signed;

  seq_state_e state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [31:0] hi_q, hi_nxt, lo_q, lo_nxt;
  logic [31:0] op_a_q, op_a_nxt, op_b_q, op_b_nxt;
  logic       mul_start_q, mul_start_nxt, mul_signed_q, mul_signed_nxt;
  logic       div_start_q, div_start_nxt, div_signed_q, div_signed_nxt;
  logic       dbz_q, dbz_nxt;

  muldiv_decode u_decode (
    .id_valid  (id_valid),
    .id_op     (id_op),
    .id_func   (id_func),
    .cls       (cls),
    .is_signed (is_signed)
  );

  // Only HI/LO instructions wait for a busy unit; everything else flows.
  assign stall = (state != ST_IDLE) && (cls != CLS_NONE);

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    hi_nxt         = hi_q;
    lo_nxt         = lo_q;
    op_a_nxt       = op_a_q;
    op_b_nxt       = op_b_q;
    mul_signed_nxt = mul_signed_q;
    div_signed_nxt = div_signed_q;
    mul_start_nxt  = 1'b0;
    div_start_nxt  = 1'b0;
    dbz_nxt        = 1'b0;

    case (state)
      ST_IDLE: begin
        case (cls)
          CLS_MUL: begin
            op_a_nxt       = rs_val;
            op_b_nxt       = rt_val;
            mul_signed_nxt = is_signed;
            mul_start_nxt  = 1'b1;
            cnt_nxt        = 4'(MUL_LATENCY);
            state_nxt      = ST_MUL_WAIT;
          end
          CLS_DIV: begin
            // A zero divisor never reaches the divider; HI/LO stay put.
            if (rt_val == 32'd0) begin
              dbz_nxt = 1'b1;
            end else begin
              op_a_nxt       = rs_val;
              op_b_nxt       = rt_val;
              div_signed_nxt = is_signed;
              div_start_nxt  = 1'b1;
              state_nxt      = ST_DIV_WAIT;
            end
          end
          CLS_MTHI: hi_nxt = rs_val;
          CLS_MTLO: lo_nxt = rs_val;
          default: ;
        endcase
      end
      ST_MUL_WAIT: begin
        // cnt counts edges left; the product is sampled on the cnt==1 edge.
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          hi_nxt    = unit.mul_result[63:32];
          lo_nxt    = unit.mul_result[31:0];
          state_nxt = ST_IDLE;
        end
      end
      ST_DIV_WAIT: begin
        if (unit.div_done) begin
          hi_nxt    = unit.div_rem;
          lo_nxt    = unit.div_quot;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= 4'd0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      op_a_q       <= 32'd0;
      op_b_q       <= 32'd0;
      mul_signed_q <= 1'b0;
      div_signed_q <= 1'b0;
      mul_start_q  <= 1'b0;
      div_start_q  <= 1'b0;
      dbz_q        <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      hi_q         <= hi_nxt;
      lo_q         <= lo_nxt;
      op_a_q       <= op_a_nxt;
      op_b_q       <= op_b_nxt;
      mul_signed_q <= mul_signed_nxt;
      div_signed_q <= div_signed_nxt;
      mul_start_q  <= mul_start_nxt;
      div_start_q  <= div_start_nxt;
      dbz_q        <= dbz_nxt;
    end
  end

  assign unit.op_a       = op_a_q;
  assign unit.op_b       = op_b_q;
  assign unit.mul_start  = mul_start_q;
  assign unit.mul_signed = mul_signed_q;
  assign unit.div_start  = div_start_q;
  assign unit.div_signed = div_signed_q;
  assign div_by_zero     = dbz_q;
  assign hi_out          = hi_q;
  assign lo_out          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed scenarios followed by random
// instruction streams, all checked cycle by cycle against a transaction-level
// reference model that also plays the multiplier and divider units.
module tb_muldiv_sequencer;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [5:0]  id_op;
  logic [5:0]  id_func;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        stall;
  logic        div_by_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  muldiv_sequencer_if ifc();

  muldiv_sequencer #(.MUL_LATENCY(L)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_op       (id_op),
    .id_func     (id_func),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .stall       (stall),
    .unit        (ifc),
    .div_by_zero (div_by_zero),
    .hi_out      (hi_out),
    .lo_out      (lo_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction currently held in ID.
  logic        cur_v;
  logic [5:0]  cur_op, cur_fn;
  logic [31:0] cur_rs, cur_rt;

  // Reference model: what the architecture should look like.
  bit          m_mul_busy, m_div_busy;
  int          m_mul_left;      // edges left until the product lands
  int          m_div_delay;     // cycles until the divider reports done
  logic [63:0] m_prod;
  logic [31:0] m_quot, m_rem;
  logic [31:0] m_hi, m_lo, m_opa, m_opb;
  bit          e_mul_start, e_div_start, e_dbz, e_msgn, e_dsgn;
  bit          force_done;      // drive a stray div_done while not dividing
  int          force_delay;     // 0 = random divider latency

  // 0 NONE, 1 MUL, 2 DIV, 3 MFHI, 4 MFLO, 5 MTHI, 6 MTLO
  function automatic int cls_of(input logic v, input logic [5:0] op, input logic [5:0] fn);
    if (!v || op != 6'h00) return 0;
    case (fn)
      6'h18, 6'h19: return 1;
      6'h1A, 6'h1B: return 2;
      6'h10: return 3;
      6'h12: return 4;
      6'h11: return 5;
      6'h13: return 6;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_mul_busy = 0; m_div_busy = 0; m_mul_left = 0; m_div_delay = 0;
    m_hi = '0; m_lo = '0; m_opa = '0; m_opb = '0;
    e_mul_start = 0; e_div_start = 0; e_dbz = 0;
  endtask

  task automatic set_cur(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt);
    cur_v = v; cur_op = op; cur_fn = fn; cur_rs = rs; cur_rt = rt;
  endtask

  // One clock cycle, entered #1 after a rising edge; returns predicted stall.
  task automatic cycle(input bit rst, output bit st);
    int c;
    logic [63:0] ua, ub;
    int sa, sb;
    rst_n = !rst;
    id_valid = cur_v; id_op = cur_op; id_func = cur_fn;
    rs_val = cur_rs; rt_val = cur_rt;

    // Unit models: real data only when it is due, noise otherwise.
    if (m_mul_busy && m_mul_left == 1) ifc.mul_result = m_prod;
    else ifc.mul_result = {$urandom(), $urandom()};
    ifc.div_done = 1'b0;
    ifc.div_quot = $urandom();
    ifc.div_rem  = $urandom();
    if (m_div_busy) begin
      if (m_div_delay == 0) begin
        ifc.div_done = 1'b1; ifc.div_quot = m_quot; ifc.div_rem = m_rem;
      end
    end else if (force_done || $urandom_range(0, 9) == 0) begin
      ifc.div_done = 1'b1;
    end

    @(negedge clk);
    c  = cls_of(cur_v, cur_op, cur_fn);
    st = (m_mul_busy || m_div_busy) && (c != 0);
    chk("stall", stall, st);
    chk("hi_out", hi_out, m_hi);
    chk("lo_out", lo_out, m_lo);
    chk("mul_start", ifc.mul_start, e_mul_start);
    chk("div_start", ifc.div_start, e_div_start);
    chk("div_by_zero", div_by_zero, e_dbz);
    chk("op_a", ifc.op_a, m_opa);
    chk("op_b", ifc.op_b, m_opb);
    if (e_mul_start) chk("mul_signed", ifc.mul_signed, e_msgn);
    if (e_div_start) chk("div_signed", ifc.div_signed, e_dsgn);

    if (rst) begin
      model_reset();
    end else begin
      e_mul_start = 0; e_div_start = 0; e_dbz = 0;
      if (m_mul_busy) begin
        m_mul_left--;
        if (m_mul_left == 0) begin
          m_hi = m_prod[63:32]; m_lo = m_prod[31:0]; m_mul_busy = 0;
        end
      end else if (m_div_busy) begin
        if (m_div_delay == 0) begin
          m_hi = m_rem; m_lo = m_quot; m_div_busy = 0;
        end else begin
          m_div_delay--;
        end
      end else begin
        case (c)
          1: begin
            e_msgn = (cur_fn == 6'h18);
            if (e_msgn) m_prod = 64'(longint'($signed(cur_rs)) * longint'($signed(cur_rt)));
            else begin
              ua = {32'h0, cur_rs}; ub = {32'h0, cur_rt}; m_prod = ua * ub;
            end
            m_opa = cur_rs; m_opb = cur_rt;
            e_mul_start = 1; m_mul_busy = 1; m_mul_left = L;
          end
          2: begin
            if (cur_rt == 32'd0) e_dbz = 1;
            else begin
              e_dsgn = (cur_fn == 6'h1A);
              if (e_dsgn) begin
                sa = $signed(cur_rs); sb = $signed(cur_rt);
                if (cur_rs == 32'h8000_0000 && sb == -1) begin
                  m_quot = cur_rs; m_rem = 32'd0;
                end else begin
                  m_quot = 32'(sa / sb); m_rem = 32'(sa % sb);
                end
              end else begin
                m_quot = cur_rs / cur_rt; m_rem = cur_rs % cur_rt;
              end
              m_opa = cur_rs; m_opb = cur_rt;
              e_div_start = 1; m_div_busy = 1;
              m_div_delay = (force_delay != 0) ? force_delay : $urandom_range(1, 10);
            end
          end
          5: m_hi = cur_rs;
          6: m_lo = cur_rs;
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Hold an instruction in ID until the model says it proceeds.
  task automatic issue(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt, output int nstall);
    bit st;
    set_cur(v, op, fn, rs, rt);
    nstall = 0;
    for (int i = 0; i < 64; i++) begin
      cycle(1'b0, st);
      if (!st) return;
      nstall++;
    end
    chk("issue_timeout", 64'(nstall), 64'd0);
  endtask

  task automatic idle_cycles(input int n);
    bit st;
    set_cur(1'b0, 6'h00, 6'h00, 32'd0, 32'd0);
    for (int i = 0; i < n; i++) cycle(1'b0, st);
  endtask

  initial begin
    int n;
    bit st;
    logic [5:0] fns [10];
    fns = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12, 6'h11, 6'h13, 6'h20, 6'h21};
    force_done = 0; force_delay = 0;
    rst_n = 1'b0;
    set_cur(1'b0, 6'h00, 6'h00, 32'd0, 32'd0);
    id_valid = 0; id_op = 0; id_func = 0; rs_val = 0; rt_val = 0;
    ifc.mul_result = '0; ifc.div_done = 0; ifc.div_quot = 0; ifc.div_rem = 0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    cycle(1'b1, st);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_stall", stall, 1'b0);

    // MULT -2 * 3, then MFLO waits out the multiplier.
    issue(1'b1, 6'h00, 6'h18, 32'hFFFF_FFFE, 32'd3, n);
    issue(1'b1, 6'h00, 6'h12, 32'd0, 32'd0, n);
    chk("mul_stall_cycles", 64'(n), 64'(L));
    chk("mult_hi", hi_out, 32'hFFFF_FFFF);
    chk("mult_lo", lo_out, 32'hFFFF_FFFA);

    // DIVU 7/2 with a 10-cycle divider; MFHI held until after done.
    force_delay = 10;
    issue(1'b1, 6'h00, 6'h1B, 32'd7, 32'd2, n);
    issue(1'b1, 6'h00, 6'h10, 32'd0, 32'd0, n);
    force_delay = 0;
    chk("div_stall_cycles", 64'(n), 64'd11);
    chk("divu_hi", hi_out, 32'd1);
    chk("divu_lo", lo_out, 32'd3);

    // Divide by zero: ignored, flagged, no stall.
    issue(1'b1, 6'h00, 6'h1A, 32'd5, 32'd0, n);
    issue(1'b1, 6'h00, 6'h10, 32'd0, 32'd0, n);
    chk("dbz_stall", 64'(n), 64'd0);
    chk("dbz_hi", hi_out, 32'd1);
    chk("dbz_lo", lo_out, 32'd3);

    // MTHI then MFHI back to back.
    issue(1'b1, 6'h00, 6'h11, 32'h1234_5678, 32'd0, n);
    issue(1'b1, 6'h00, 6'h10, 32'd0, 32'd0, n);
    chk("mthi_stall", 64'(n), 64'd0);
    chk("mthi_hi", hi_out, 32'h1234_5678);

    // Non-HI/LO traffic and stray div_done during a multiply and in idle.
    force_done = 1;
    issue(1'b1, 6'h00, 6'h19, 32'd5, 32'd7, n);
    issue(1'b1, 6'h00, 6'h20, 32'd1, 32'd2, n);
    chk("add_no_stall", 64'(n), 64'd0);
    idle_cycles(L + 2);
    force_done = 0;
    chk("multu_hi", hi_out, 32'd0);
    chk("multu_lo", lo_out, 32'd35);

    // Reset in the middle of a divide, then a late div_done.
    force_delay = 10;
    issue(1'b1, 6'h00, 6'h1B, 32'd100, 32'd7, n);
    force_delay = 0;
    idle_cycles(2);
    set_cur(1'b1, 6'h00, 6'h10, 32'd0, 32'd0);
    cycle(1'b1, st);
    force_done = 1;
    idle_cycles(1);
    force_done = 0;
    chk("rst_mid_hi", hi_out, 32'd0);
    chk("rst_mid_lo", lo_out, 32'd0);
    issue(1'b1, 6'h00, 6'h10, 32'd0, 32'd0, n);
    chk("rst_mid_stall", 64'(n), 64'd0);

    // Random instruction stream with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      logic       v;
      logic [5:0] op;
      logic [31:0] rs, rt;
      v  = ($urandom_range(0, 9) != 0);
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
      rs = $urandom();
      rt = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
      if ($urandom_range(0, 3) == 0) rs = 32'($urandom_range(0, 20));
      if ($urandom_range(0, 49) == 0) begin
        set_cur(v, op, fns[$urandom_range(0, 9)], rs, rt);
        cycle(1'b1, st);
      end else begin
        issue(v, op, fns[$urandom_range(0, 9)], rs, rt, n);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequences the multi-cycle multiply and divide units of the 54-instruction pipeline and owns the architectural HI/LO registers. It classifies the instruction in the ID stage from its op/func fields and issues MULT/MULTU to the multiplier and DIV/DIVU to the iterative divider. It captures results into HI/LO, executes MFHI/MFLO/MTHI/MTLO ordering, and stalls IF/ID while a HI/LO hazard exists.

## Interface
Parameters:
- MUL_LATENCY, 4, rising edges from accept edge to the multiplier-result sampling edge; legal range 1..15.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- id_valid  in  1  ID stage holds a valid, non-flushed instruction.
- id_op  in  6  instruction[31:26].
- id_func  in  6  instruction[5:0].
- rs_val  in  32  forwarded rs operand.
- rt_val  in  32  forwarded rt operand.
- stall  out  1  hold IF/ID and bubble EX; combinational from state and ID inputs.
- op_a, op_b  out  32  registered operands to both units.
- mul_start  out  1  one-cycle pulse.
- mul_signed  out  1  1 = MULT, 0 = MULTU; held with op_a/op_b.
- mul_result  in  64  {hi, lo} product.
- div_start  out  1  one-cycle pulse.
- div_signed  out  1  1 = DIV, 0 = DIVU.
- div_done  in  1  divider completion pulse, at least 1 cycle after div_start.
- div_quot, div_rem  in  32  valid while div_done = 1.
- div_by_zero  out  1  one-cycle pulse on an ignored zero-divisor divide.
- hi_out, lo_out  out  32  architectural HI/LO, registered.

## Operation
- Classes, all with id_op = 6'h00:
  - func 18/19 is MULT/MULTU.
  - func 1A/1B is DIV/DIVU.
  - func 10/12 is MFHI/MFLO.
  - func 11/13 is MTHI/MTLO.
  - Everything else is class NONE.
- A HI/LO instruction is id_valid=1 with class not NONE.
- States:
  - IDLE (reset state).
  - MUL_WAIT.
  - DIV_WAIT.
- IDLE, MULT/MULTU:
  - Accept on the edge.
  - op_a ← rs_val, op_b ← rt_val, mul_signed set.
  - mul_start = 1 for the following cycle.
  - cnt ← MUL_LATENCY; next state MUL_WAIT.
- IDLE, DIV/DIVU with rt_val ≠ 0:
  - Same operand latching; div_start pulses.
  - Next state DIV_WAIT.
- IDLE, DIV/DIVU with rt_val = 0:
  - No start is issued; HI/LO are unchanged and the state stays IDLE.
  - div_by_zero pulses the next cycle.
- IDLE, MTHI/MTLO: HI (or LO) ← rs_val on the edge.
- IDLE, MFHI/MFLO: no action; the datapath reads hi_out/lo_out directly.
- MUL_WAIT:
  - cnt decrements each edge.
  - On the edge where cnt = 1: {HI, LO} ← mul_result and next state IDLE.
- DIV_WAIT: on the edge with div_done = 1, HI ← div_rem, LO ← div_quot, and next state IDLE.
- stall = (state ≠ IDLE) and a HI/LO instruction is in ID. Other instructions flow freely during busy states.
- Nothing is accepted while stall = 1.
- div_done is ignored outside DIV_WAIT.
- mul_result is ignored except on the capture edge.
- Reset (rst_n = 0 at an edge):
  - state ← IDLE, cnt ← 0.
  - HI, LO, op_a, op_b ← 0.
  - All pulses are 0, overriding any in-flight operation.

## Timing
- Accept edge E0 sets the registered start/operand outputs during cycle E0→E1.
- Multiply:
  - Capture happens at edge E0 + MUL_LATENCY.
  - stall can be high for exactly MUL_LATENCY cycles after E0.
  - An MFHI held in ID proceeds in the cycle after capture and sees the new HI.
- Divide:
  - Capture happens at the div_done edge.
  - stall drops in the cycle after that edge.
- Back-to-back:
  - A HI/LO instruction arriving in the cycle right after capture is accepted in IDLE.
  - There is no extra bubble.
- On every capture, new HI/LO are visible on hi_out/lo_out the cycle after the capture edge.
- Reset outputs:
  - stall follows from state = IDLE, so it is 0.
  - mul_start, div_start, div_by_zero = 0.
  - hi_out, lo_out, op_a, op_b = 0.

## Structure
- Shared package cpu54_pkg holds:
  - The SPECIAL op constant (6'h00).
  - The eight func code constants.
  - The HI/LO class enum (NONE, MUL, DIV, MFHI, MFLO, MTHI, MTLO).
  - The sequencer state enum.
- Sub-module muldiv_decode is purely combinational:
  - Inputs are id_op, id_func, id_valid.
  - Outputs are the class and the signed flag.
- The FSM, counter and HI/LO registers live in muldiv_sequencer.

## Test plan
- MULT with rs = 32'hFFFF_FFFE (−2), rt = 3, MUL_LATENCY = 4, model returning the product → mul_start one cycle; stall high 4 cycles for a following MFLO; HI = FFFF_FFFF, LO = FFFF_FFFA.
- DIVU 7/2 with div_done 10 cycles after start → LO = 3, HI = 1; a trailing MFHI stalls until the cycle after div_done.
- DIV with rt_val = 0 → no div_start; div_by_zero pulses once; HI/LO unchanged; no stall.
- MTHI 32'h1234_5678 in IDLE, then MFHI next cycle → hi_out = 1234_5678; no stall.
- During MUL_WAIT, an ADD in ID → stall = 0. A spurious div_done in MUL_WAIT or IDLE → HI/LO unchanged.
- rst_n = 0 mid DIV_WAIT, then a late div_done → state IDLE, HI = LO = 0, stall = 0, div_done ignored.
